// File: rtl/psum_tree_reducer_if.sv
// Beat, result and bias-FIFO signals of the partial-sum reducer.
// The PE-array side uses the master view; the reducer uses the slave view.
interface psum_tree_reducer_if #(
  parameter int LANES      = 256,
  parameter int PSUM_W     = 6,
  parameter int ADDR_W     = 12,
  parameter int BIAS_W     = 16,
  parameter int BIAS_DEPTH = 8,
  parameter int OUT_W      = 8
);
  localparam int CW = $clog2(BIAS_DEPTH + 1);

  logic                      i_valid;
  logic [LANES*PSUM_W-1:0]   psum_in;
  logic [ADDR_W-1:0]         address_in;
  logic                      mode;
  logic [4:0]                shift;
  logic                      layer_finish;
  logic [BIAS_W-1:0]         bias_in;
  logic                      bias_valid;
  logic                      err_clr;
  logic                      o_valid;
  logic [OUT_W-1:0]          o_data;
  logic [ADDR_W-1:0]         address_out;
  logic                      o_last;
  logic                      bias_full;
  logic                      bias_empty;
  logic [CW-1:0]             bias_count;
  logic                      bias_ovf;
  logic                      bias_unf;

  modport master (
    output i_valid, psum_in, address_in, mode, shift, layer_finish,
           bias_in, bias_valid, err_clr,
    input  o_valid, o_data, address_out, o_last,
           bias_full, bias_empty, bias_count, bias_ovf, bias_unf
  );

  modport slave (
    input  i_valid, psum_in, address_in, mode, shift, layer_finish,
           bias_in, bias_valid, err_clr,
    output o_valid, o_data, address_out, o_last,
           bias_full, bias_empty, bias_count, bias_ovf, bias_unf
  );
endinterface

// File: rtl/psum_tree_reducer.sv
// Pipelined adder-tree reduction of LANES signed partial sums, plus bias from
// an internal FIFO, then binary or ReLU/shift/saturate activation.
module psum_tree_reducer #(
  parameter int LANES      = 256,
  parameter int PSUM_W     = 6,
  parameter int ADDR_W     = 12,
  parameter int BIAS_W     = 16,
  parameter int BIAS_DEPTH = 8,
  parameter int OUT_W      = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  psum_tree_reducer_if.slave  bus
);
  localparam int LOG2L  = $clog2(LANES);
  localparam int SUM_W  = PSUM_W + LOG2L;
  localparam int TW     = ((SUM_W > BIAS_W) ? SUM_W : BIAS_W) + 1;
  localparam int PW     = $clog2(BIAS_DEPTH);
  localparam int CW     = $clog2(BIAS_DEPTH + 1);
  localparam int LAST_D = LOG2L + 4;

  function automatic logic [OUT_W-1:0] sat_act(input logic signed [TW-1:0] t,
                                               input logic md, input logic [4:0] sh);
    logic signed [TW-1:0] r;
    sat_act = '0;
    r = t >>> sh;
    if (!md)
      sat_act[0] = ~t[TW-1];
    else if (!t[TW-1])
      sat_act = (|r[TW-1:OUT_W]) ? '1 : r[OUT_W-1:0];
  endfunction

  logic [LOG2L:0]     vld_p;
  logic [LOG2L:0]     mode_p;
  logic [ADDR_W-1:0]  addr_p  [LOG2L+1];
  logic [4:0]         shift_p [LOG2L+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p <= '0;
    else        vld_p <= {vld_p[LOG2L-1:0], bus.i_valid};
  end

  always_ff @(posedge clk) begin
    if (bus.i_valid) begin
      addr_p[0]  <= bus.address_in;
      mode_p[0]  <= bus.mode;
      shift_p[0] <= bus.shift;
    end
    for (int s = 1; s <= LOG2L; s++) begin
      addr_p[s]  <= addr_p[s-1];
      mode_p[s]  <= mode_p[s-1];
      shift_p[s] <= shift_p[s-1];
    end
  end

  // Stage 0 captures lanes on a beat; stages 1..LOG2L each halve the count, growing one bit.
  for (genvar s = 0; s <= LOG2L; s++) begin : g_lvl
    localparam int W = PSUM_W + s;
    localparam int N = LANES >> s;
    logic signed [W-1:0] sum_p [N];
    if (s == 0) begin : g_in
      always_ff @(posedge clk)
        if (bus.i_valid)
          for (int k = 0; k < N; k++) sum_p[k] <= bus.psum_in[k*PSUM_W +: PSUM_W];
    end else begin : g_add
      always_ff @(posedge clk)
        for (int k = 0; k < N; k++)
          sum_p[k] <= W'(g_lvl[s-1].sum_p[2*k]) + W'(g_lvl[s-1].sum_p[2*k+1]);
    end
  end

  logic signed [BIAS_W-1:0] mem [BIAS_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            cnt_q, cnt_nxt;
  logic                     full_q, empty_q, ovf_q, unf_q;
  logic                     pop_req, pop_do, push_ok, unf_ev, ovf_ev;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [BIAS_W-1:0] bias_head;
  logic signed [TW-1:0]     t_sum;

  assign sum_s = g_lvl[LOG2L].sum_p[0];

  // Post stage: pop bias head (zero when empty) and form the exact biased total.
  always_comb begin
    pop_req   = vld_p[LOG2L];
    pop_do    = pop_req && !empty_q;
    push_ok   = bus.bias_valid && (!full_q || pop_do);
    unf_ev    = pop_req && empty_q;
    ovf_ev    = bus.bias_valid && !push_ok;
    bias_head = pop_do ? mem[rd_ptr] : '0;
    t_sum     = TW'(sum_s) + TW'(bias_head);
    cnt_nxt   = cnt_q + CW'(push_ok) - CW'(pop_do);
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= bus.bias_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_do)  rd_ptr <= rd_ptr + PW'(1);
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(BIAS_DEPTH));
      empty_q <= (cnt_nxt == '0);
      if (ovf_ev)           ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (unf_ev)           unf_q <= 1'b1;
      else if (bus.err_clr) unf_q <= 1'b0;
    end
  end

  logic              o_valid_q;
  logic [OUT_W-1:0]  o_data_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [LAST_D-1:0] last_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      addr_out_q <= '0;
      last_sr    <= '0;
    end else begin
      o_valid_q <= pop_req;
      if (pop_req) begin
        o_data_q   <= sat_act(t_sum, mode_p[LOG2L], shift_p[LOG2L]);
        addr_out_q <= addr_p[LOG2L];
      end
      last_sr <= {last_sr[LAST_D-2:0], bus.layer_finish};
    end
  end

  assign bus.o_valid     = o_valid_q;
  assign bus.o_data      = o_data_q;
  assign bus.address_out = addr_out_q;
  assign bus.o_last      = last_sr[LAST_D-1];
  assign bus.bias_count  = cnt_q;
  assign bus.bias_full   = full_q;
  assign bus.bias_empty  = empty_q;
  assign bus.bias_ovf    = ovf_q;
  assign bus.bias_unf    = unf_q;
endmodule

// File: tb/tb_psum_tree_reducer.sv
// Directed and random beats against a queue-based model of the reducer.
module tb_psum_tree_reducer;
  localparam int LANES = 256, PSUM_W = 6, ADDR_W = 12, BIAS_W = 16, BIAS_DEPTH = 8, OUT_W = 8;
  localparam int LOG2L = $clog2(LANES);
  localparam int CW    = $clog2(BIAS_DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  psum_tree_reducer_if #(.LANES(LANES), .PSUM_W(PSUM_W), .ADDR_W(ADDR_W), .BIAS_W(BIAS_W),
                         .BIAS_DEPTH(BIAS_DEPTH), .OUT_W(OUT_W)) bus ();

  psum_tree_reducer #(.LANES(LANES), .PSUM_W(PSUM_W), .ADDR_W(ADDR_W), .BIAS_W(BIAS_W),
                      .BIAS_DEPTH(BIAS_DEPTH), .OUT_W(OUT_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int pop_at; int s; int addr; bit md; int sh; } beat_t;

  int    errors = 0, checks = 0;
  beat_t fl[$];
  int    bq[$];
  int    last_at[$];
  int    edge_n = 0;
  bit    exp_ov, exp_last, exp_ovf, exp_unf;
  int    exp_od, exp_ad;
  int    lanes[LANES];
  int    cur_sum;

  function automatic int ref_act(input longint t, input bit md, input int sh);
    longint r;
    if (!md) return (t >= 0) ? 1 : 0;
    if (t < 0) return 0;
    r = t >> sh;
    return (r > 2**OUT_W - 1) ? 2**OUT_W - 1 : int'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".o_valid"},     bus.o_valid, exp_ov);
    chk({ph, ".o_data"},      bus.o_data, exp_od);
    chk({ph, ".address_out"}, bus.address_out, exp_ad);
    chk({ph, ".o_last"},      bus.o_last, exp_last);
    chk({ph, ".bias_count"},  bus.bias_count, bq.size());
    chk({ph, ".bias_empty"},  bus.bias_empty, bq.size() == 0);
    chk({ph, ".bias_full"},   bus.bias_full, bq.size() == BIAS_DEPTH);
    chk({ph, ".bias_ovf"},    bus.bias_ovf, exp_ovf);
    chk({ph, ".bias_unf"},    bus.bias_unf, exp_unf);
  endtask

  // Model effect of the coming clock edge from the inputs currently driven.
  task automatic model_edge();
    bit     ev_u, ev_o;
    longint bias;
    beat_t  b;
    ev_u = 0; ev_o = 0; exp_ov = 0; exp_last = 0;
    if (fl.size() != 0 && fl[0].pop_at == edge_n) begin
      b = fl.pop_front();
      bias = 0;
      if (bq.size() == 0) ev_u = 1;
      else bias = bq.pop_front();
      exp_ov = 1;
      exp_od = ref_act(b.s + bias, b.md, b.sh);
      exp_ad = b.addr;
    end
    if (bus.i_valid)
      fl.push_back('{pop_at: edge_n + LOG2L + 1, s: cur_sum, addr: int'(bus.address_in),
                     md: bus.mode, sh: int'(bus.shift)});
    if (bus.bias_valid) begin
      if (bq.size() < BIAS_DEPTH) bq.push_back(int'($signed(bus.bias_in)));
      else ev_o = 1;
    end
    if (ev_u) exp_unf = 1; else if (bus.err_clr) exp_unf = 0;
    if (ev_o) exp_ovf = 1; else if (bus.err_clr) exp_ovf = 0;
    if (last_at.size() != 0 && last_at[0] == edge_n) begin
      exp_last = 1;
      void'(last_at.pop_front());
    end
    if (bus.layer_finish) last_at.push_back(edge_n + LOG2L + 3);
    edge_n++;
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
    bus.i_valid = 0; bus.bias_valid = 0; bus.layer_finish = 0; bus.err_clr = 0;
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) step(ph);
  endtask

  task automatic pack();
    cur_sum = 0;
    for (int k = 0; k < LANES; k++) begin
      bus.psum_in[k*PSUM_W +: PSUM_W] = PSUM_W'(lanes[k]);
      cur_sum += lanes[k];
    end
  endtask

  task automatic lanes_const(input int v);
    for (int k = 0; k < LANES; k++) lanes[k] = v;
    pack();
  endtask

  task automatic lanes_rand();
    for (int k = 0; k < LANES; k++) lanes[k] = int'($urandom_range(63)) - 32;
    pack();
  endtask

  task automatic beat(input bit md, input int sh, input int addr);
    bus.i_valid = 1; bus.mode = md; bus.shift = 5'(sh); bus.address_in = ADDR_W'(addr);
  endtask

  task automatic push(input int v);
    bus.bias_valid = 1; bus.bias_in = BIAS_W'(v);
  endtask

  task automatic do_reset(input string ph);
    bus.i_valid = 0; bus.bias_valid = 0; bus.layer_finish = 0; bus.err_clr = 0;
    rst_n = 0;
    #1;
    fl.delete(); bq.delete(); last_at.delete();
    exp_ov = 0; exp_od = 0; exp_ad = 0; exp_last = 0; exp_ovf = 0; exp_unf = 0;
    check_all(ph);
    @(posedge clk);
    edge_n++;
    #1;
    rst_n = 1;
  endtask

  initial begin
    bus.i_valid = 0; bus.psum_in = '0; bus.address_in = '0; bus.mode = 0; bus.shift = '0;
    bus.layer_finish = 0; bus.bias_in = '0; bus.bias_valid = 0; bus.err_clr = 0;
    exp_ov = 0; exp_od = 0; exp_ad = 0; exp_last = 0; exp_ovf = 0; exp_unf = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1;

    // All lanes +1, zero bias: threshold, saturation, shift by 2.
    lanes_const(1);
    for (int i = 0; i < 3; i++) begin push(0); step("ones_push"); end
    beat(0, 0, 'h011); step("ones");
    beat(1, 0, 'h012); step("ones");
    beat(1, 2, 'h013); bus.layer_finish = 1; step("ones");
    idle(14, "ones_drain");

    // All lanes -32: T=-1 twice, then T=0 equality.
    lanes_const(-32);
    push(8191); step("neg_push");
    push(8191); step("neg_push");
    push(8192); step("neg_push");
    beat(0, 0, 'h021); step("neg");
    beat(1, 0, 'h022); step("neg");
    beat(0, 0, 'h023); step("neg");
    idle(12, "neg_drain");

    // Biases 1..8 then 12 zero-sum beats: last 4 underflow.
    lanes_const(0);
    for (int i = 1; i <= 8; i++) begin push(i); step("order_push"); end
    for (int i = 0; i < 12; i++) begin beat(1, 0, 'h100 + i); step("order"); end
    idle(12, "order_drain");
    bus.err_clr = 1; step("unf_clr");

    // Fill past capacity; overflow beats a same-cycle clear; push with pop while full.
    for (int i = 0; i < 9; i++) begin push(100 + i); step("fill"); end
    push(150); bus.err_clr = 1; step("ovf_vs_clr");
    beat(1, 0, 'h300); step("full_pop");
    idle(8, "full_pop_wait");
    push(200); step("full_pushpop");
    bus.err_clr = 1; step("ovf_clr");
    for (int i = 0; i < 8; i++) begin beat(1, 0, 'h310 + i); step("full_drain"); end
    idle(12, "full_drain_tail");

    // Alternating modes with distinct addresses and random lanes.
    for (int i = 0; i < 4; i++) begin push(int'($urandom_range(400)) - 200); step("alt_push"); end
    for (int i = 0; i < 4; i++) begin
      lanes_rand(); beat(i[0], 1, 'h400 + 7 * i); step("alt");
    end
    idle(12, "alt_drain");

    // Random traffic with bubbles, pushes, clears and layer ends.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 55) begin
        lanes_rand();
        if ($urandom_range(3) == 0)
          for (int k = 0; k < LANES; k++) lanes[k] = int'($urandom_range(31));
        pack();
        beat(1'($urandom_range(1)), int'($urandom_range(7)), int'($urandom_range(4095)));
      end
      if ($urandom_range(99) < 60) push(int'($urandom_range(6000)) - 3000);
      if ($urandom_range(99) < 4)  bus.err_clr = 1;
      if ($urandom_range(99) < 5)  bus.layer_finish = 1;
      step("rand");
    end
    idle(14, "rand_drain");

    // Reset with beats in flight and a stocked FIFO.
    for (int i = 0; i < 3; i++) begin push(5 + i); step("rst_push"); end
    lanes_const(2);
    for (int i = 0; i < 5; i++) begin beat(1, 0, 'h500 + i); step("rst_beats"); end
    do_reset("rst_mid");
    idle(15, "rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
